// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/hold sequencer for the 5-stage RV32I core
//
// Purpose: tracks in-flight destinations (EX, MEM) in a shadow scoreboard,
// stalls on load-use RAW hazards seen in ID, freezes the back end while data
// memory is busy and squashes wrong-path fetches after a taken branch/jump.
// Counts stall/hold cycles in a saturating counter.
//
// Build option: HAZARD_NOFWD_EN - core built without forwarding; stall on any
// RAW against a valid EX or MEM destination, repeating until none remains.
//
// Ports:
//   clk, rst_n   core clock, synchronous active-low reset
//   VALID_ID     IF/ID holds a real instruction
//   OPCODE_ID    opcode of the ID instruction
//   RS1_ID/RS2_ID/RD_ID  register fields of the ID instruction
//   PCSrc_EX     branch/jump resolved taken in EX
//   MEM_READY    data memory completes the MEM access this cycle
//   PC_WRITE     PC update enable
//   IF_ID_WRITE  IF/ID load enable
//   IF_ID_FLUSH  clear IF/ID to a bubble
//   ID_EX_FLUSH  load a bubble into ID/EX
//   PIPE_HOLD    freeze ID/EX, EX/MEM, MEM/WB
//   STALL_CNT    saturating count of stall/hold cycles

module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             VALID_ID,
   input  logic [6:0]       OPCODE_ID,
   input  logic [4:0]       RS1_ID,
   input  logic [4:0]       RS2_ID,
   input  logic [4:0]       RD_ID,
   input  logic             PCSrc_EX,
   input  logic             MEM_READY,
   output logic             PC_WRITE,
   output logic             IF_ID_WRITE,
   output logic             IF_ID_FLUSH,
   output logic             ID_EX_FLUSH,
   output logic             PIPE_HOLD,
   output logic [CNT_W-1:0] STALL_CNT
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_FLUSH} state_t;

   state_t            r_state;
   logic [1:0]        r_flush_cnt;
   logic              r_ex_valid, r_ex_is_load, r_ex_is_mem;
   logic [4:0]        r_ex_rd;
   logic              r_mem_valid, r_mem_is_mem;
   logic [4:0]        r_mem_rd;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_use_rs1, w_use_rs2;
   logic w_mem_wait, w_branch, w_flush_tail, w_if_id_flush;
   logic w_ex_hit, w_mem_hit, w_raw, w_stall, w_id_ex_flush;
   logic w_id_is_load, w_id_is_mem, w_id_no_rd;

   function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic use1,
                                    input logic use2);
      return (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
   endfunction

   always_comb begin
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      case (OPCODE_ID)
         OP_R, OP_STORE, OP_BRANCH: begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
         OP_IMM, OP_LOAD, OP_JALR:  w_use_rs1 = 1'b1;
         default: ;
      endcase
   end

   assign w_id_is_load = (OPCODE_ID == OP_LOAD);
   assign w_id_is_mem  = (OPCODE_ID == OP_LOAD) || (OPCODE_ID == OP_STORE);
   // Stores and branches carry immediate bits in the rd field; record them as
   // writing x0 so they never look like a producer.
   assign w_id_no_rd   = (OPCODE_ID == OP_STORE) || (OPCODE_ID == OP_BRANCH);

   assign w_mem_wait    = r_mem_valid && r_mem_is_mem && !MEM_READY;
   assign w_branch      = PCSrc_EX && !w_mem_wait;
   // A flush tail interrupted by a memory wait resumes once the wait ends.
   assign w_flush_tail  = (r_flush_cnt != 2'd0) && (r_state != ST_RUN) && !w_mem_wait;
   assign w_if_id_flush = w_branch || w_flush_tail;

   assign w_ex_hit  = r_ex_valid  && src_hit(r_ex_rd,  RS1_ID, RS2_ID, w_use_rs1, w_use_rs2);
   assign w_mem_hit = r_mem_valid && src_hit(r_mem_rd, RS1_ID, RS2_ID, w_use_rs1, w_use_rs2);
`ifdef HAZARD_NOFWD_EN
   assign w_raw = w_ex_hit || w_mem_hit;
`else
   assign w_raw = w_ex_hit && r_ex_is_load;
`endif
   assign w_stall       = VALID_ID && w_raw && !w_mem_wait && !w_if_id_flush;
   assign w_id_ex_flush = w_branch || w_stall;

   always_comb begin
      PC_WRITE    = 1'b0;
      IF_ID_WRITE = 1'b0;
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
      PIPE_HOLD   = 1'b0;
      if (rst_n) begin
         if (w_mem_wait) begin
            IF_ID_FLUSH = 1'b0;
            ID_EX_FLUSH = 1'b0;
            PIPE_HOLD   = 1'b1;
         end else begin
            PC_WRITE    = !w_stall;
            IF_ID_WRITE = !w_stall;
            IF_ID_FLUSH = w_if_id_flush;
            ID_EX_FLUSH = w_id_ex_flush;
         end
      end
   end

   assign STALL_CNT = r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_RUN;
         r_flush_cnt  <= 2'd0;
         r_ex_valid   <= 1'b0;
         r_ex_rd      <= 5'd0;
         r_ex_is_load <= 1'b0;
         r_ex_is_mem  <= 1'b0;
         r_mem_valid  <= 1'b0;
         r_mem_rd     <= 5'd0;
         r_mem_is_mem <= 1'b0;
         r_stall_cnt  <= '0;
      end else begin
         if (!w_mem_wait) begin
            r_mem_valid  <= r_ex_valid;
            r_mem_rd     <= r_ex_rd;
            r_mem_is_mem <= r_ex_is_mem;
            r_ex_valid   <= VALID_ID && !w_id_ex_flush;
            r_ex_rd      <= w_id_no_rd ? 5'd0 : RD_ID;
            r_ex_is_load <= w_id_is_load;
            r_ex_is_mem  <= w_id_is_mem;
         end

         if (w_mem_wait) begin
            r_state <= ST_MEM_WAIT;
         end else if (w_branch) begin
            r_flush_cnt <= FLUSH_RELOAD;
            r_state     <= (FLUSH_RELOAD != 2'd0) ? ST_FLUSH : ST_RUN;
         end else if (r_flush_cnt != 2'd0) begin
            r_flush_cnt <= r_flush_cnt - 2'd1;
            r_state     <= (r_flush_cnt == 2'd1) ? ST_RUN : ST_FLUSH;
         end else begin
            r_state <= ST_RUN;
         end

         if ((w_stall || w_mem_wait) && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             VALID_ID;
   logic [6:0]       OPCODE_ID;
   logic [4:0]       RS1_ID, RS2_ID, RD_ID;
   logic             PCSrc_EX, MEM_READY;
   logic             PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, PIPE_HOLD;
   logic [CNT_W-1:0] STALL_CNT;

   wire [4:0] w_out = {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_FLUSH, PIPE_HOLD};

   int               checks = 0;
   int               passes = 0;
   logic [CNT_W-1:0] exp_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .VALID_ID(VALID_ID), .OPCODE_ID(OPCODE_ID),
      .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID), .PCSrc_EX(PCSrc_EX),
      .MEM_READY(MEM_READY), .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE),
      .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH), .PIPE_HOLD(PIPE_HOLD),
      .STALL_CNT(STALL_CNT)
   );

   task automatic id(input logic v, input logic [6:0] op, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd);
      VALID_ID = v; OPCODE_ID = op; RS1_ID = r1; RS2_ID = r2; RD_ID = rd;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; PCSrc_EX = 1'b0; MEM_READY = 1'b1;
      id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick; tick;
      @(negedge clk); checks++;
      if (w_out !== 5'b00110) $display("FAIL rst_out got=%b exp=%b", w_out, 5'b00110); else passes++;
      checks++;
      if (STALL_CNT !== 4'd0) $display("FAIL rst_cnt got=%0d exp=0", STALL_CNT); else passes++;
      rst_n = 1'b1; exp_cnt = '0;
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL run_idle got=%b exp=%b", w_out, 5'b11000); else passes++;
      tick;
   endtask

   task automatic test_load_use;
      logic [4:0] e;
      id(1'b1, OP_LOAD, 5'd2, 5'd0, 5'd5);
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL lu_issue got=%b exp=%b", w_out, 5'b11000); else passes++;
      tick;
      id(1'b1, OP_R, 5'd5, 5'd7, 5'd6);
      @(negedge clk); checks++;
      if (w_out !== 5'b00010) $display("FAIL lu_stall got=%b exp=%b", w_out, 5'b00010); else passes++;
      tick; exp_cnt++;
`ifdef HAZARD_NOFWD_EN
      e = 5'b00010;
`else
      e = 5'b11000;
`endif
      @(negedge clk); checks++;
      if (w_out !== e) $display("FAIL lu_after got=%b exp=%b", w_out, e); else passes++;
      checks++;
      if (STALL_CNT !== exp_cnt) $display("FAIL lu_cnt got=%0d exp=%0d", STALL_CNT, exp_cnt); else passes++;
      tick;
      if (e == 5'b00010) exp_cnt++;
      id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick;
   endtask

   task automatic test_x0_unused;
      id(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0);
      tick;
      id(1'b1, OP_R, 5'd0, 5'd0, 5'd1);
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL x0_nostall got=%b exp=%b", w_out, 5'b11000); else passes++;
      tick;
      id(1'b1, OP_LOAD, 5'd2, 5'd0, 5'd5);
      tick;
      id(1'b1, OP_LUI, 5'd5, 5'd5, 5'd5);
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL lui_nostall got=%b exp=%b", w_out, 5'b11000); else passes++;
      tick;
      id(1'b1, OP_LOAD, 5'd2, 5'd0, 5'd5);
      tick;
      id(1'b1, OP_IMM, 5'd2, 5'd5, 5'd1);
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL addi_rs2_unused got=%b exp=%b", w_out, 5'b11000); else passes++;
      tick;
      id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick; tick;
      @(negedge clk); checks++;
      if (STALL_CNT !== exp_cnt) $display("FAIL x0_cnt got=%0d exp=%0d", STALL_CNT, exp_cnt); else passes++;
   endtask

   task automatic test_mem_wait;
      id(1'b1, OP_STORE, 5'd2, 5'd3, 5'd7);
      tick;
      id(1'b1, OP_LOAD, 5'd2, 5'd0, 5'd5);
      tick;
      id(1'b1, OP_R, 5'd5, 5'd0, 5'd6);
      MEM_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); checks++;
         if (w_out !== 5'b00001) $display("FAIL mw_hold%0d got=%b exp=%b", i, w_out, 5'b00001); else passes++;
         checks++;
         if (STALL_CNT !== exp_cnt) $display("FAIL mw_cnt%0d got=%0d exp=%0d", i, STALL_CNT, exp_cnt); else passes++;
         tick; exp_cnt++;
      end
      MEM_READY = 1'b1;
      @(negedge clk); checks++;
      if (w_out !== 5'b00010) $display("FAIL mw_release_frozen got=%b exp=%b", w_out, 5'b00010); else passes++;
      checks++;
      if (STALL_CNT !== exp_cnt) $display("FAIL mw_cnt3 got=%0d exp=%0d", STALL_CNT, exp_cnt); else passes++;
      tick; exp_cnt++;
      id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      MEM_READY = 1'b0; PCSrc_EX = 1'b1;
      @(negedge clk); checks++;
      if (w_out !== 5'b00001) $display("FAIL mw_branch_ignored got=%b exp=%b", w_out, 5'b00001); else passes++;
      tick; exp_cnt++;
      MEM_READY = 1'b1;
      @(negedge clk); checks++;
      if (w_out !== 5'b11110) $display("FAIL mw_branch_release got=%b exp=%b", w_out, 5'b11110); else passes++;
      tick;
      PCSrc_EX = 1'b0;
      @(negedge clk); checks++;
      if (w_out !== 5'b11100) $display("FAIL mw_flush_tail got=%b exp=%b", w_out, 5'b11100); else passes++;
      tick;
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL mw_back_run got=%b exp=%b", w_out, 5'b11000); else passes++;
      checks++;
      if (STALL_CNT !== exp_cnt) $display("FAIL mw_cnt_end got=%0d exp=%0d", STALL_CNT, exp_cnt); else passes++;
   endtask

   task automatic test_branch;
      id(1'b1, OP_LOAD, 5'd2, 5'd0, 5'd5);
      tick;
      id(1'b1, OP_R, 5'd5, 5'd7, 5'd6);
      PCSrc_EX = 1'b1;
      @(negedge clk); checks++;
      if (w_out !== 5'b11110) $display("FAIL br_suppress got=%b exp=%b", w_out, 5'b11110); else passes++;
      tick;
      PCSrc_EX = 1'b0;
      @(negedge clk); checks++;
      if (w_out !== 5'b11100) $display("FAIL br_tail got=%b exp=%b", w_out, 5'b11100); else passes++;
      tick;
      id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL br_done got=%b exp=%b", w_out, 5'b11000); else passes++;
      PCSrc_EX = 1'b1;
      tick;
      @(negedge clk); checks++;
      if (w_out !== 5'b11110) $display("FAIL br_reload got=%b exp=%b", w_out, 5'b11110); else passes++;
      tick;
      PCSrc_EX = 1'b0;
      @(negedge clk); checks++;
      if (w_out !== 5'b11100) $display("FAIL br_reload_tail got=%b exp=%b", w_out, 5'b11100); else passes++;
      tick;
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL br_reload_done got=%b exp=%b", w_out, 5'b11000); else passes++;
      checks++;
      if (STALL_CNT !== exp_cnt) $display("FAIL br_cnt got=%0d exp=%0d", STALL_CNT, exp_cnt); else passes++;
   endtask

   task automatic test_reset_mem_wait;
      id(1'b1, OP_STORE, 5'd2, 5'd3, 5'd0);
      tick;
      id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick;
      MEM_READY = 1'b0;
      @(negedge clk); checks++;
      if (w_out !== 5'b00001) $display("FAIL rmw_hold got=%b exp=%b", w_out, 5'b00001); else passes++;
      tick;
      rst_n = 1'b0;
      @(negedge clk); checks++;
      if (w_out !== 5'b00110) $display("FAIL rmw_forced got=%b exp=%b", w_out, 5'b00110); else passes++;
      tick;
      rst_n = 1'b1; exp_cnt = '0;
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL rmw_run got=%b exp=%b", w_out, 5'b11000); else passes++;
      checks++;
      if (STALL_CNT !== exp_cnt) $display("FAIL rmw_cnt got=%0d exp=0", STALL_CNT); else passes++;
      MEM_READY = 1'b1;
      tick;
   endtask

   task automatic test_saturate;
      id(1'b1, OP_STORE, 5'd2, 5'd3, 5'd0);
      tick;
      id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick;
      MEM_READY = 1'b0;
      repeat (20) tick;
      @(negedge clk); checks++;
      if (w_out !== 5'b00001) $display("FAIL sat_hold got=%b exp=%b", w_out, 5'b00001); else passes++;
      checks++;
      if (STALL_CNT !== 4'hF) $display("FAIL sat_cnt got=%0d exp=15", STALL_CNT); else passes++;
      MEM_READY = 1'b1;
      tick;
   endtask

`ifdef HAZARD_NOFWD_EN
   task automatic test_nofwd;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      id(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
      tick;
      id(1'b1, OP_R, 5'd3, 5'd1, 5'd4);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); checks++;
         if (w_out !== 5'b00010) $display("FAIL nf_stall%0d got=%b exp=%b", i, w_out, 5'b00010); else passes++;
         tick;
      end
      @(negedge clk); checks++;
      if (w_out !== 5'b11000) $display("FAIL nf_release got=%b exp=%b", w_out, 5'b11000); else passes++;
      checks++;
      if (STALL_CNT !== 4'd2) $display("FAIL nf_cnt got=%0d exp=2", STALL_CNT); else passes++;
      id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
      tick;
   endtask
`endif

   initial begin
      test_reset;
      test_load_use;
      test_x0_unused;
      test_mem_wait;
      test_branch;
      test_reset_mem_wait;
      test_saturate;
`ifdef HAZARD_NOFWD_EN
      test_nofwd;
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
